spi_xfer_sequencer: RTL and testbench

Command-driven master for the 8-bit SPI core's 3-bit-address register port. It accepts a transfer command of N bytes, streams TX bytes into the core and RX bytes out, and handles slave-select, status polling and error capture. The CPU is no longer needed for byte-level polling. It sits between a fabric requester (DMA or FSM) and the SPI core instance.

---
 rtl/spi_seq_pkg.sv | 41 ++++
 rtl/spi_reg_access.sv | 113 +++++++++++
 rtl/spi_xfer_sequencer.sv | 272 +++++++++++++++++++++++++++
 tb/tb_spi_xfer_sequencer.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_seq_pkg.sv
// Shared definitions for the SPI transfer sequencer: SPI core register map,
// status/control bit positions, FSM state encodings and a status helper.
package spi_seq_pkg;

   // SPI core register addresses
   localparam logic [2:0] RXDATA  = 3'd0;
   localparam logic [2:0] TXDATA  = 3'd1;
   localparam logic [2:0] STATUS  = 3'd2;
   localparam logic [2:0] CONTROL = 3'd3;
   localparam logic [2:0] SSEL    = 3'd5;
   localparam logic [2:0] EOPV    = 3'd6;

   // Status register bit positions
   localparam int ST_ROE  = 3;
   localparam int ST_TOE  = 4;
   localparam int ST_TMT  = 5;
   localparam int ST_TRDY = 6;
   localparam int ST_RRDY = 7;

   // Control register: forced slave-select output
   localparam int          CTL_SSO    = 10;
   localparam logic [15:0] CTL_SS_ON  = 16'h0001 << CTL_SSO;
   localparam logic [15:0] CTL_SS_OFF = 16'h0000;

   // Main sequencer states
   typedef enum logic [3:0] {
      S_IDLE, S_SEL, S_CLR, S_SSON, S_TXW, S_PT, S_WR,
      S_PR, S_RD, S_RXO, S_PE, S_SSOFF, S_FIN
   } state_e;

   // Register access unit phases: two strobe cycles then one recovery cycle
   typedef enum logic [1:0] {
      RAU_IDLE, RAU_C1, RAU_C2, RAU_REC
   } rau_phase_e;

   // Overrun on either direction is reported as an error
   function automatic logic status_error(input logic [15:0] status);
      return status[ST_ROE] | status[ST_TOE];
   endfunction

endpackage

// File: rtl/spi_reg_access.sv
// Register access unit: performs one fixed 3-cycle read or write on the SPI
// core register port per 'go'. Cycles 1-2 strobe, cycle 3 recovers and
// reports acc_done with read data captured at the end of cycle 2.
module spi_reg_access
   import spi_seq_pkg::*;
(
   input  logic        clk,
   input  logic        reset_n,
   input  logic        go,
   input  logic        we,
   input  logic [2:0]  addr,
   input  logic [15:0] wdata,
   output logic        acc_done,
   output logic [15:0] rdata,
   output logic        spi_chipselect,
   output logic [2:0]  spi_addr,
   output logic [15:0] spi_wdata,
   output logic        spi_read_n,
   output logic        spi_write_n,
   input  logic [15:0] spi_rdata
);

   rau_phase_e  phase_q, phase_d;
   logic        cs_q, cs_d;
   logic [2:0]  addr_q, addr_d;
   logic [15:0] wdata_q, wdata_d;
   logic        read_n_q, read_n_d;
   logic        write_n_q, write_n_d;
   logic [15:0] rdata_q, rdata_d;
   logic        acc_done_q, acc_done_d;

   // Next-state logic for the access phase and the registered core strobes
   always_comb begin
      phase_d    = phase_q;
      cs_d       = cs_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      read_n_d   = read_n_q;
      write_n_d  = write_n_q;
      rdata_d    = rdata_q;
      acc_done_d = 1'b0;
      case (phase_q)
         RAU_IDLE: begin
            if (go) begin
               phase_d   = RAU_C1;
               cs_d      = 1'b1;
               addr_d    = addr;
               wdata_d   = wdata;
               read_n_d  = we;
               write_n_d = ~we;
            end else begin
               phase_d = RAU_IDLE;
            end
         end
         RAU_C1: begin
            phase_d = RAU_C2;
         end
         RAU_C2: begin
            phase_d    = RAU_REC;
            cs_d       = 1'b0;
            addr_d     = 3'd0;
            wdata_d    = 16'h0000;
            read_n_d   = 1'b1;
            write_n_d  = 1'b1;
            rdata_d    = spi_rdata;
            acc_done_d = 1'b1;
         end
         RAU_REC: begin
            phase_d = RAU_IDLE;
         end
         default: begin
            phase_d   = RAU_IDLE;
            cs_d      = 1'b0;
            addr_d    = 3'd0;
            wdata_d   = 16'h0000;
            read_n_d  = 1'b1;
            write_n_d = 1'b1;
         end
      endcase
   end

   // Access unit state and core-facing registers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         phase_q    <= RAU_IDLE;
         cs_q       <= 1'b0;
         addr_q     <= 3'd0;
         wdata_q    <= 16'h0000;
         read_n_q   <= 1'b1;
         write_n_q  <= 1'b1;
         rdata_q    <= 16'h0000;
         acc_done_q <= 1'b0;
      end else begin
         phase_q    <= phase_d;
         cs_q       <= cs_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         read_n_q   <= read_n_d;
         write_n_q  <= write_n_d;
         rdata_q    <= rdata_d;
         acc_done_q <= acc_done_d;
      end
   end

   assign acc_done       = acc_done_q;
   assign rdata          = rdata_q;
   assign spi_chipselect = cs_q;
   assign spi_addr       = addr_q;
   assign spi_wdata      = wdata_q;
   assign spi_read_n     = read_n_q;
   assign spi_write_n    = write_n_q;

endmodule

// File: rtl/spi_xfer_sequencer.sv
// Command-driven SPI transfer sequencer. Runs an N-byte exchange through the
// SPI core register port: selects the slave, clears stale status, forces SS,
// then per byte: take TX byte, wait TRDY, write, wait RRDY, read, hand RX byte
// out. Finishes by waiting TMT and (optionally) releasing SS.
module spi_xfer_sequencer
   import spi_seq_pkg::*;
#(
   parameter logic [15:0] SS_MASK    = 16'h0001,
   parameter int          POLL_LIMIT = 1023,
   parameter int          PW         = 10
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [7:0]  cmd_len,
   input  logic        cmd_keep_ss,
   input  logic [7:0]  tx_data,
   input  logic        tx_valid,
   output logic        tx_ready,
   output logic [7:0]  rx_data,
   output logic        rx_valid,
   input  logic        rx_ready,
   output logic        busy,
   output logic        done,
   output logic        err,
   output logic        spi_chipselect,
   output logic [2:0]  spi_addr,
   output logic [15:0] spi_wdata,
   output logic        spi_read_n,
   output logic        spi_write_n,
   input  logic [15:0] spi_rdata
);

   state_e        state_q, state_d;
   logic          issued_q, issued_d;
   logic [8:0]    cnt_q, cnt_d;
   logic [PW-1:0] poll_q, poll_d;
   logic [7:0]    byte_q, byte_d;
   logic          keep_ss_q, keep_ss_d;
   logic          tmo_q, tmo_d;
   logic          cmd_ready_q, cmd_ready_d;
   logic          tx_ready_q, tx_ready_d;
   logic          rx_valid_q, rx_valid_d;
   logic [7:0]    rx_data_q, rx_data_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;
   logic          err_q, err_d;

   logic          go_s;
   logic          we_s;
   logic [2:0]    addr_s;
   logic [15:0]   wdata_s;
   logic          acc_done_s;
   logic [15:0]   rdata_s;
   logic          status_rd_s;
   logic          poll_limit_s;
   logic          unused_rdata_s;

   assign unused_rdata_s = ^{rdata_s[15:8], rdata_s[2:0]};
   assign poll_limit_s   = (poll_q == PW'(POLL_LIMIT));
   assign status_rd_s    = acc_done_s &
                           ((state_q == S_PT) | (state_q == S_PR) | (state_q == S_PE));

   spi_reg_access u_rau (
      .clk            (clk),
      .reset_n        (reset_n),
      .go             (go_s),
      .we             (we_s),
      .addr           (addr_s),
      .wdata          (wdata_s),
      .acc_done       (acc_done_s),
      .rdata          (rdata_s),
      .spi_chipselect (spi_chipselect),
      .spi_addr       (spi_addr),
      .spi_wdata      (spi_wdata),
      .spi_read_n     (spi_read_n),
      .spi_write_n    (spi_write_n),
      .spi_rdata      (spi_rdata)
   );

   // Sequencer next-state, access requests and handshake outputs
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      byte_d     = byte_q;
      keep_ss_d  = keep_ss_q;
      tmo_d      = tmo_q;
      rx_valid_d = rx_valid_q;
      rx_data_d  = rx_data_q;
      done_d     = 1'b0;
      err_d      = err_q;
      tx_ready_d = 1'b0;
      we_s       = 1'b0;
      addr_s     = 3'd0;
      wdata_s    = 16'h0000;
      // every state except the handshake ones issues one register access
      go_s       = ~issued_q;
      case (state_q)
         S_IDLE: begin
            go_s = 1'b0;
            if (cmd_valid) begin
               cnt_d     = (cmd_len == 8'd0) ? 9'd256 : {1'b0, cmd_len};
               keep_ss_d = cmd_keep_ss;
               err_d     = 1'b0;
               tmo_d     = 1'b0;
               state_d   = S_SEL;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_SEL: begin
            we_s    = 1'b1;
            addr_s  = SSEL;
            wdata_s = SS_MASK;
            state_d = acc_done_s ? S_CLR : S_SEL;
         end
         S_CLR: begin
            we_s    = 1'b1;
            addr_s  = STATUS;
            state_d = acc_done_s ? S_SSON : S_CLR;
         end
         S_SSON: begin
            we_s    = 1'b1;
            addr_s  = CONTROL;
            wdata_s = CTL_SS_ON;
            state_d = acc_done_s ? S_TXW : S_SSON;
         end
         S_TXW: begin
            // tx_ready is raised for one cycle; the byte is taken in that cycle
            go_s = 1'b0;
            if (tx_ready_q) begin
               byte_d  = tx_data;
               state_d = S_PT;
            end else begin
               tx_ready_d = tx_valid;
               state_d    = S_TXW;
            end
         end
         S_PT: begin
            addr_s = STATUS;
            if (acc_done_s && rdata_s[ST_TRDY]) begin
               state_d = S_WR;
            end else if (acc_done_s && poll_limit_s) begin
               tmo_d   = 1'b1;
               err_d   = 1'b1;
               state_d = S_SSOFF;
            end else begin
               state_d = S_PT;
            end
         end
         S_WR: begin
            we_s    = 1'b1;
            addr_s  = TXDATA;
            wdata_s = {8'h00, byte_q};
            state_d = acc_done_s ? S_PR : S_WR;
         end
         S_PR: begin
            addr_s = STATUS;
            if (acc_done_s && rdata_s[ST_RRDY]) begin
               state_d = S_RD;
            end else if (acc_done_s && poll_limit_s) begin
               tmo_d   = 1'b1;
               err_d   = 1'b1;
               state_d = S_SSOFF;
            end else begin
               state_d = S_PR;
            end
         end
         S_RD: begin
            addr_s = RXDATA;
            if (acc_done_s) begin
               rx_data_d  = rdata_s[7:0];
               rx_valid_d = 1'b1;
               state_d    = S_RXO;
            end else begin
               state_d = S_RD;
            end
         end
         S_RXO: begin
            go_s = 1'b0;
            if (rx_valid_q && rx_ready) begin
               rx_valid_d = 1'b0;
               cnt_d      = cnt_q - 9'd1;
               state_d    = (cnt_q == 9'd1) ? S_PE : S_TXW;
            end else begin
               state_d = S_RXO;
            end
         end
         S_PE: begin
            addr_s = STATUS;
            if (acc_done_s && rdata_s[ST_TMT]) begin
               state_d = keep_ss_q ? S_FIN : S_SSOFF;
            end else if (acc_done_s && poll_limit_s) begin
               tmo_d   = 1'b1;
               err_d   = 1'b1;
               state_d = S_SSOFF;
            end else begin
               state_d = S_PE;
            end
         end
         S_SSOFF: begin
            we_s    = 1'b1;
            addr_s  = CONTROL;
            wdata_s = CTL_SS_OFF;
            state_d = acc_done_s ? S_FIN : S_SSOFF;
         end
         S_FIN: begin
            go_s    = 1'b0;
            done_d  = 1'b1;
            state_d = S_IDLE;
         end
         default: begin
            go_s       = 1'b0;
            rx_valid_d = 1'b0;
            state_d    = S_IDLE;
         end
      endcase
      // overrun flags are sticky errors but do not stop the transfer
      err_d       = err_d | (status_rd_s & status_error(rdata_s));
      // poll count restarts whenever the state changes, counts failed polls
      poll_d      = (state_d != state_q) ? '0 :
                    (status_rd_s ? poll_q + PW'(1) : poll_q);
      issued_d    = acc_done_s ? 1'b0 : (issued_q | go_s);
      cmd_ready_d = (state_d == S_IDLE);
      busy_d      = (state_d != S_IDLE) & (state_d != S_FIN);
   end

   // Sequencer state and registered outputs
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= S_IDLE;
         issued_q    <= 1'b0;
         cnt_q       <= 9'd0;
         poll_q      <= '0;
         byte_q      <= 8'h00;
         keep_ss_q   <= 1'b0;
         tmo_q       <= 1'b0;
         cmd_ready_q <= 1'b1;
         tx_ready_q  <= 1'b0;
         rx_valid_q  <= 1'b0;
         rx_data_q   <= 8'h00;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         issued_q    <= issued_d;
         cnt_q       <= cnt_d;
         poll_q      <= poll_d;
         byte_q      <= byte_d;
         keep_ss_q   <= keep_ss_d;
         tmo_q       <= tmo_d;
         cmd_ready_q <= cmd_ready_d;
         tx_ready_q  <= tx_ready_d;
         rx_valid_q  <= rx_valid_d;
         rx_data_q   <= rx_data_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         err_q       <= err_d;
      end
   end

   assign cmd_ready = cmd_ready_q;
   assign tx_ready  = tx_ready_q;
   assign rx_valid  = rx_valid_q;
   assign rx_data   = rx_data_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign err       = err_q;

endmodule

// File: tb/tb_spi_xfer_sequencer.sv
// Bench for spi_xfer_sequencer: a loopback SPI core register model plus a
// scoreboard of sent bytes compared against received bytes, and directed
// scenarios for SS handling, back-pressure, stalls, overruns and reset.
module tb_spi_xfer_sequencer;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        cmd_valid, cmd_ready, cmd_keep_ss;
   logic [7:0]  cmd_len;
   logic [7:0]  tx_data, rx_data;
   logic        tx_valid, tx_ready, rx_valid, rx_ready;
   logic        busy, done, err;
   logic        spi_chipselect, spi_read_n, spi_write_n;
   logic [2:0]  spi_addr;
   logic [15:0] spi_wdata, spi_rdata;

   int vectors = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   spi_xfer_sequencer dut (
      .clk(clk), .reset_n(reset_n),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_len(cmd_len), .cmd_keep_ss(cmd_keep_ss),
      .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
      .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
      .busy(busy), .done(done), .err(err),
      .spi_chipselect(spi_chipselect), .spi_addr(spi_addr), .spi_wdata(spi_wdata),
      .spi_read_n(spi_read_n), .spi_write_n(spi_write_n), .spi_rdata(spi_rdata)
   );

   // ---------------- loopback SPI core model ----------------
   int          xfer_delay = 2;
   bit          stall_rrdy = 1'b0;
   bit          force_toe  = 1'b0;
   logic [7:0]  m_rx, m_txb;
   logic        m_busy, m_rrdy, m_roe, m_toe, strobe_prev;
   int          m_timer;
   logic [15:0] m_ctrl, m_ssel, m_last_ctrl;
   int          n_writes, n_ctrl_writes, rd2_since_tx;
   int          acc_log[$];
   logic        ss_n;
   logic        new_acc;

   assign ss_n    = ~m_ctrl[10];
   assign new_acc = spi_chipselect && (!spi_read_n || !spi_write_n) && !strobe_prev;

   always_comb begin
      case (spi_addr)
         3'd0:    spi_rdata = {8'h00, m_rx};
         3'd2:    spi_rdata = {8'h00, m_rrdy, !m_busy, !m_busy, m_toe | force_toe, m_roe, 3'b000};
         3'd3:    spi_rdata = m_ctrl;
         3'd5:    spi_rdata = m_ssel;
         default: spi_rdata = 16'h0000;
      endcase
   end

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         m_rx <= 8'h00; m_txb <= 8'h00; m_busy <= 1'b0; m_rrdy <= 1'b0;
         m_roe <= 1'b0; m_toe <= 1'b0; strobe_prev <= 1'b0; m_timer <= 0;
         m_ctrl <= 16'h0000; m_ssel <= 16'h0000;
      end else begin
         strobe_prev <= spi_chipselect && (!spi_read_n || !spi_write_n);
         if (m_busy) begin
            if (m_timer <= 1) begin
               m_busy <= 1'b0;
               m_rx   <= m_txb;
               if (!stall_rrdy) begin
                  m_rrdy <= 1'b1;
                  if (m_rrdy) m_roe <= 1'b1;
               end
            end else begin
               m_timer <= m_timer - 1;
            end
         end
         if (new_acc && !spi_write_n) begin
            n_writes <= n_writes + 1;
            case (spi_addr)
               3'd1: begin m_busy <= 1'b1; m_timer <= xfer_delay; m_txb <= spi_wdata[7:0]; rd2_since_tx <= 0; end
               3'd2: begin m_rrdy <= 1'b0; m_roe <= 1'b0; m_toe <= 1'b0; end
               3'd3: begin m_ctrl <= spi_wdata; m_last_ctrl <= spi_wdata; n_ctrl_writes <= n_ctrl_writes + 1; end
               3'd5: m_ssel <= spi_wdata;
               default: ;
            endcase
         end
         if (new_acc && !spi_read_n) begin
            if (spi_addr == 3'd0) m_rrdy <= 1'b0;
            if (spi_addr == 3'd2) rd2_since_tx <= rd2_since_tx + 1;
         end
      end
   end

   always @(posedge clk) begin
      if (reset_n && new_acc) acc_log.push_back(int'(spi_addr));
   end

   // ---------------- monitors ----------------
   int done_cnt = 0, txr_cnt = 0, rxv_cnt = 0;
   always @(negedge clk) begin
      if (done) done_cnt++;
      if (tx_ready) txr_cnt++;
      if (rx_valid) rxv_cnt++;
      if (tx_ready || rx_valid) begin
         vectors++;
         assert (!(tx_ready && rx_valid)) else begin
            miscompares++;
            $error("FAIL tx_rx_exclusive: observed tx_ready=%0b rx_valid=%0b expected not both", tx_ready, rx_valid);
         end
      end
   end

   // ---------------- helpers ----------------
   logic [7:0] exp_q[$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic start_cmd(input logic [7:0] len, input logic keep);
      @(negedge clk);
      chk("cmd_ready_idle", cmd_ready, 1);
      cmd_valid = 1'b1; cmd_len = len; cmd_keep_ss = keep;
      @(negedge clk);
      cmd_valid = 1'b0;
      chk("busy_after_accept", busy, 1);
      chk("cmd_ready_while_busy", cmd_ready, 0);
      chk("err_cleared_on_accept", err, 0);
   endtask

   task automatic send_tx(input logic [7:0] b, input string tag);
      int k = 0;
      tx_data = b; tx_valid = 1'b1;
      while (!tx_ready && k < 3000) begin @(negedge clk); k++; end
      chk({tag, "_tx_handshake"}, tx_ready, 1);
      exp_q.push_back(b);
      @(negedge clk);
      tx_valid = 1'b0; tx_data = 8'h00;
      chk({tag, "_tx_ready_one_cycle"}, tx_ready, 0);
   endtask

   task automatic xfer_byte(input logic [7:0] b, input int hold, input string tag);
      int k = 0;
      int w0, t0;
      logic [7:0] e;
      send_tx(b, tag);
      chk({tag, "_ss_low"}, ss_n, 0);
      rx_ready = (hold == 0);
      while (!rx_valid && k < 3000) begin @(negedge clk); k++; end
      chk({tag, "_rx_valid"}, rx_valid, 1);
      if (hold > 0) begin
         w0 = n_writes; t0 = txr_cnt;
         repeat (hold) @(negedge clk);
         chk({tag, "_rx_held"}, rx_valid, 1);
         chk({tag, "_no_core_writes_while_held"}, n_writes, w0);
         chk({tag, "_no_tx_ready_while_held"}, txr_cnt, t0);
         rx_ready = 1'b1;
      end
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
      chk({tag, "_rx_data"}, rx_data, e);
      @(negedge clk);
      rx_ready = 1'b0;
      chk({tag, "_rx_valid_dropped"}, rx_valid, 0);
   endtask

   task automatic wait_done(input int bound, input string tag);
      int k = 0;
      int d0 = done_cnt;
      while (!done && k < bound) begin @(negedge clk); k++; end
      chk({tag, "_done"}, done, 1);
      chk({tag, "_cmd_ready_at_done"}, cmd_ready, 1);
      chk({tag, "_busy_at_done"}, busy, 0);
      @(negedge clk);
      chk({tag, "_done_one_cycle"}, done, 0);
      chk({tag, "_done_count"}, done_cnt - d0, 1);
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      int log0, d0, c0, rx0, k;
      int exp_order[9] = '{5, 2, 3, 2, 1, 2, 0, 2, 3};
      n_writes = 0; n_ctrl_writes = 0; rd2_since_tx = 0; m_last_ctrl = 16'hFFFF;
      reset_n = 1'b0; cmd_valid = 1'b0; cmd_len = 8'h00; cmd_keep_ss = 1'b0;
      tx_data = 8'h00; tx_valid = 1'b0; rx_ready = 1'b0;

      // reset state
      @(negedge clk);
      chk("rst_cmd_ready", cmd_ready, 1);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_err", err, 0);
      chk("rst_chipselect", spi_chipselect, 0);
      chk("rst_read_n", spi_read_n, 1);
      chk("rst_write_n", spi_write_n, 1);
      @(negedge clk);
      reset_n = 1'b1;

      // single byte, access order
      log0 = acc_log.size();
      start_cmd(8'd1, 1'b0);
      xfer_byte(8'hA5, 0, "single");
      wait_done(2000, "single");
      chk("single_access_count", acc_log.size() - log0, 9);
      for (int i = 0; i < 9; i++)
         chk($sformatf("single_access_%0d", i),
             (log0 + i < acc_log.size()) ? acc_log[log0 + i] : -1, exp_order[i]);
      chk("single_last_ctrl", m_last_ctrl, 16'h0000);
      chk("single_ss_released", ss_n, 1);

      // 256-byte transfer with cmd_len=0
      d0 = done_cnt;
      start_cmd(8'd0, 1'b0);
      for (int i = 0; i < 256; i++) begin
         if (i == 255) chk("len256_no_early_done", done_cnt - d0, 0);
         xfer_byte(8'(i), 0, $sformatf("len256_b%0d", i));
      end
      wait_done(2000, "len256");

      // TOE reported during transfer: err set, data still delivered
      force_toe = 1'b1;
      start_cmd(8'd1, 1'b0);
      xfer_byte(8'h5A, 0, "toe");
      wait_done(2000, "toe");
      chk("toe_err", err, 1);
      force_toe = 1'b0;

      // keep_ss with slow core (polling exercised), then normal release
      xfer_delay = 12;
      c0 = n_ctrl_writes;
      start_cmd(8'd2, 1'b1);
      xfer_byte(8'h12, 0, "keep_b0");
      xfer_byte(8'h34, 0, "keep_b1");
      wait_done(2000, "keep");
      chk("keep_ctrl_writes", n_ctrl_writes - c0, 1);
      chk("keep_last_ctrl", m_last_ctrl, 16'h0400);
      chk("keep_ss_low_after_done", ss_n, 0);
      xfer_delay = 2;
      start_cmd(8'd1, 1'b0);
      xfer_byte(8'h77, 0, "rel");
      wait_done(2000, "rel");
      chk("rel_ss_high", ss_n, 1);
      chk("rel_last_ctrl", m_last_ctrl, 16'h0000);

      // rx back-pressure for 50 cycles on byte 1
      start_cmd(8'd2, 1'b0);
      xfer_byte(8'hC3, 50, "bp_b0");
      xfer_byte(8'h3C, 0, "bp_b1");
      wait_done(2000, "bp");

      // core stalls RRDY: timeout after 1024 status reads, SS forced off
      stall_rrdy = 1'b1;
      rx0 = rxv_cnt;
      start_cmd(8'd1, 1'b1);
      send_tx(8'h99, "stall");
      void'(exp_q.pop_front());
      wait_done(12000, "stall");
      chk("stall_err", err, 1);
      chk("stall_status_reads", rd2_since_tx, 1024);
      chk("stall_last_ctrl", m_last_ctrl, 16'h0000);
      chk("stall_ss_high", ss_n, 1);
      chk("stall_no_rx", rxv_cnt - rx0, 0);

      // asynchronous reset while polling RRDY
      start_cmd(8'd1, 1'b0);
      send_tx(8'h42, "rstmid");
      void'(exp_q.pop_front());
      k = 0;
      while (rd2_since_tx < 3 && k < 500) begin @(negedge clk); k++; end
      chk("rstmid_in_poll", rd2_since_tx >= 3, 1);
      @(negedge clk);
      #2 reset_n = 1'b0;
      #1;
      chk("rstmid_cmd_ready", cmd_ready, 1);
      chk("rstmid_busy", busy, 0);
      chk("rstmid_tx_ready", tx_ready, 0);
      chk("rstmid_rx_valid", rx_valid, 0);
      chk("rstmid_rx_data", rx_data, 8'h00);
      chk("rstmid_err", err, 0);
      chk("rstmid_chipselect", spi_chipselect, 0);
      chk("rstmid_read_n", spi_read_n, 1);
      chk("rstmid_write_n", spi_write_n, 1);
      chk("rstmid_addr", spi_addr, 3'd0);
      chk("rstmid_wdata", spi_wdata, 16'h0000);
      chk("rstmid_ss_high", ss_n, 1);
      stall_rrdy = 1'b0;
      @(negedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      start_cmd(8'd1, 1'b0);
      xfer_byte(8'hE1, 0, "after_rst");
      wait_done(2000, "after_rst");
      chk("after_rst_err", err, 0);
      chk("after_rst_ss_high", ss_n, 1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
